// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage rvpipeline: forwarding, load-use, flush, mem freeze.
// Optional perf counters enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemAccessM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemReqM,
    output logic        MemTimeout,
    output logic [31:0] LoadStallCnt,
    output logic [31:0] FlushCnt,
    output logic [31:0] MemWaitCnt
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             timeoutNext;
    logic             freeze;
    logic             reqRaw;
    logic             lwStall;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic       wrM,
        input logic [4:0] rdM,
        input logic       wrW,
        input logic [4:0] rdW
    );
        if (wrM && rdM != 5'd0 && rdM == rs) return 2'b10;
        if (wrW && rdW != 5'd0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    assign lwStall = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        timeoutNext = MemTimeout;
        freeze      = 1'b0;
        reqRaw      = 1'b0;
        unique case (state)
            IDLE: begin
                reqRaw = MemAccessM;
                freeze = MemAccessM && !MemReadyM;
                if (MemAccessM && !MemReadyM) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                reqRaw = 1'b1;
                freeze = !MemReadyM;
                if (MemReadyM) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == CNT_W'(MAX_WAIT)) begin
                    stateNext   = ERROR;
                    timeoutNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitCntNext;
            MemTimeout <= timeoutNext;
        end
    end

    // Reset masks every control output; forwarding is never gated by freeze.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MemReqM   = 1'b0;
        if (!reset) begin
            ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            MemReqM   = reqRaw;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lsCnt;
    logic [31:0] flCnt;
    logic [31:0] mwCnt;
    logic        lwWin;
    logic        flWin;

    assign lwWin = !freeze && !PCSrcE && lwStall;
    assign flWin = !freeze && PCSrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            lsCnt <= '0;
            flCnt <= '0;
            mwCnt <= '0;
        end else begin
            if (lwWin) lsCnt <= lsCnt + 32'd1;
            if (flWin) flCnt <= flCnt + 32'd1;
            if (freeze) mwCnt <= mwCnt + 32'd1;
        end
    end

    assign LoadStallCnt = lsCnt;
    assign FlushCnt     = flCnt;
    assign MemWaitCnt   = mwCnt;
`else
    assign LoadStallCnt = 32'd0;
    assign FlushCnt     = 32'd0;
    assign MemWaitCnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus memory handshake sequences.
// Perf counter checks follow `define HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic       rwm;
        logic       rww;
        logic       loade;
        logic       pcsrc;
        logic       acc;
        logic       rdy;
    } in_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       se;
        logic       sm;
        logic       fd;
        logic       fe;
        logic       fw;
        logic       req;
        logic       tmo;
    } outs_t;

    typedef struct {
        in_t   i;
        outs_t e;
    } vec_t;

    localparam int NV = 16;

    logic        clk = 1'b0;
    in_t         cur;
    outs_t       act;
    logic [31:0] lsCnt;
    logic [31:0] flCnt;
    logic [31:0] mwCnt;
    vec_t        tbl [NV];
    outs_t       sbq [$];
    string       nmq [$];
    int          total = 0;
    int          bad = 0;
    int          expLw = 0;
    int          expFl = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (cur.rst),
        .Rs1D        (cur.rs1d),
        .Rs2D        (cur.rs2d),
        .Rs1E        (cur.rs1e),
        .Rs2E        (cur.rs2e),
        .RdE         (cur.rde),
        .RdM         (cur.rdm),
        .RdW         (cur.rdw),
        .RegWriteM   (cur.rwm),
        .RegWriteW   (cur.rww),
        .LoadE       (cur.loade),
        .PCSrcE      (cur.pcsrc),
        .MemAccessM  (cur.acc),
        .MemReadyM   (cur.rdy),
        .ForwardAE   (act.fa),
        .ForwardBE   (act.fb),
        .StallF      (act.sf),
        .StallD      (act.sd),
        .StallE      (act.se),
        .StallM      (act.sm),
        .FlushD      (act.fd),
        .FlushE      (act.fe),
        .FlushW      (act.fw),
        .MemReqM     (act.req),
        .MemTimeout  (act.tmo),
        .LoadStallCnt(lsCnt),
        .FlushCnt    (flCnt),
        .MemWaitCnt  (mwCnt)
    );

    localparam outs_t ZERO = '0;
    localparam outs_t FRZ  = '{sf:1'b1, sd:1'b1, se:1'b1, sm:1'b1,
                               fw:1'b1, req:1'b1, default:'0};
    localparam outs_t ERR  = '{sf:1'b1, sd:1'b1, se:1'b1, sm:1'b1,
                               fw:1'b1, tmo:1'b1, default:'0};

    task automatic setv(input int k, input in_t i, input outs_t e);
        tbl[k].i = i;
        tbl[k].e = e;
    endtask

    task automatic step(input in_t i, input outs_t e, input string nm);
        outs_t got;
        outs_t want;
        string wn;
        @(posedge clk);
        #1;
        cur = i;
        sbq.push_back(e);
        nmq.push_back(nm);
        #3;
        got  = act;
        want = sbq.pop_front();
        wn   = nmq.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got fa=%b fb=%b st=%b%b%b%b fl=%b%b%b req=%b tmo=%b, want fa=%b fb=%b st=%b%b%b%b fl=%b%b%b req=%b tmo=%b",
                wn, got.fa, got.fb, got.sf, got.sd, got.se, got.sm,
                got.fd, got.fe, got.fw, got.req, got.tmo,
                want.fa, want.fb, want.sf, want.sd, want.se, want.sm,
                want.fd, want.fe, want.fw, want.req, want.tmo);
        end
    endtask

    task automatic chkCnt(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chkPerf(input string nm, input int ls, input int fl, input int mw);
`ifdef HAZARD_PERF_CNT_EN
        chkCnt({nm, "_ls"}, lsCnt, 32'(ls));
        chkCnt({nm, "_fl"}, flCnt, 32'(fl));
        chkCnt({nm, "_mw"}, mwCnt, 32'(mw));
`else
        chkCnt({nm, "_ls"}, lsCnt, 32'd0);
        chkCnt({nm, "_fl"}, flCnt, 32'd0);
        chkCnt({nm, "_mw"}, mwCnt, 32'd0);
`endif
    endtask

    in_t hz;
    in_t mw;
    in_t mwFwd;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cur = '{rst:1'b1, default:'0};
        hz  = '{rst:1'b1, rwm:1'b1, rdm:5'd5, rs1e:5'd5, rs2e:5'd5,
                loade:1'b1, rde:5'd7, rs1d:5'd7, pcsrc:1'b1,
                acc:1'b1, default:'0};
        mw    = '{acc:1'b1, default:'0};
        mwFwd = '{acc:1'b1, rwm:1'b1, rdm:5'd5, rs1e:5'd5, default:'0};

        setv(0,  '{rwm:1, rdm:5, rww:1, rdw:5, rs1e:5, default:'0},
                 '{fa:2'b10, default:'0});
        setv(1,  '{rwm:1, rww:1, rdw:5, rs1e:5, default:'0},
                 '{fa:2'b01, default:'0});
        setv(2,  '{rdm:5, rww:1, rdw:5, rs1e:5, rs2e:5, default:'0},
                 '{fa:2'b01, fb:2'b01, default:'0});
        setv(3,  '{rwm:1, rdm:3, rww:1, rdw:4, rs1e:4, rs2e:3, default:'0},
                 '{fa:2'b01, fb:2'b10, default:'0});
        setv(4,  '{rwm:1, rww:1, default:'0}, ZERO);
        setv(5,  '{rwm:1, rdm:9, rdw:8, rs1e:8, rs2e:9, default:'0},
                 '{fb:2'b10, default:'0});
        setv(6,  '{loade:1, rde:7, rs2d:7, default:'0},
                 '{sf:1, sd:1, fe:1, default:'0});
        setv(7,  '{loade:1, default:'0}, ZERO);
        setv(8,  '{loade:1, rde:7, rs1d:7, pcsrc:1, default:'0},
                 '{fd:1, fe:1, default:'0});
        setv(9,  '{pcsrc:1, default:'0}, '{fd:1, fe:1, default:'0});
        setv(10, '{loade:1, rde:7, rs1d:6, rs2d:8, default:'0}, ZERO);
        setv(11, '{rde:7, rs1d:7, default:'0}, ZERO);
        setv(12, '{acc:1, rdy:1, default:'0}, '{req:1, default:'0});
        setv(13, '{rdy:1, default:'0}, ZERO);
        setv(14, '{loade:1, rde:3, rs1d:3, rwm:1, rdm:3, rs1e:3,
                   acc:1, rdy:1, default:'0},
                 '{fa:2'b10, sf:1, sd:1, fe:1, req:1, default:'0});
        setv(15, '{default:'0}, ZERO);

        step(hz, ZERO, "rst_hold0");
        step(hz, ZERO, "rst_hold1");
        chkPerf("rst", 0, 0, 0);

        for (int k = 0; k < NV; k++) begin
            step(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));
            if (tbl[k].e.fd) expFl++;
            if (tbl[k].e.fe && !tbl[k].e.fd) expLw++;
        end
        chkPerf("tbl", expLw, expFl, 0);

        // 3-cycle memory wait, then zero-wait back-to-back access
        step('{rst:1'b1, default:'0}, ZERO, "rst_a");
        step(mwFwd, '{fa:2'b10, sf:1, sd:1, se:1, sm:1, fw:1, req:1, default:'0}, "mw0");
        step(mw, FRZ, "mw1");
        step(mw, FRZ, "mw2");
        step('{acc:1, rdy:1, default:'0}, '{req:1, default:'0}, "mw_done");
        step('{acc:1, rdy:1, default:'0}, '{req:1, default:'0}, "b2b_zero");
        step('{rdy:1, default:'0}, ZERO, "mw_idle");
        chkPerf("mw", 0, 0, 3);

        // timeout with MAX_WAIT=4
        step('{rst:1'b1, default:'0}, ZERO, "rst_b");
        step(mw, FRZ, "to_idle");
        for (int k = 1; k <= 4; k++)
            step(mw, FRZ, $sformatf("to_wait%0d", k));
        step(mw, ERR, "to_err");
        step('{acc:1, rdy:1, default:'0}, ERR, "to_rdy_ign");
        step('{default:'0}, ERR, "to_hold");
        step('{rst:1'b1, default:'0}, '{tmo:1'b1, default:'0}, "to_rst0");
        step('{rst:1'b1, default:'0}, ZERO, "to_rst1");
        step('{default:'0}, ZERO, "to_after");

        // reset pulsed in the middle of a wait
        step(mw, FRZ, "mid_idle");
        step(mw, FRZ, "mid_wait");
        step('{rst:1'b1, acc:1'b1, default:'0}, ZERO, "mid_rst");
        step('{default:'0}, ZERO, "mid_after");
        step(mw, FRZ, "mid_fresh");
        step('{acc:1, rdy:1, default:'0}, '{req:1, default:'0}, "mid_done");
        step('{default:'0}, ZERO, "mid_idle2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
